// File: rtl/deserializer_if.sv
// Byte-stream in / word-stream out bundle for the deserializer.
// The slave modport is the deserializer's view; master is the view of the
// block driving bytes in and consuming words.
interface deserializer_if #(
    parameter int unsigned DEPTH = 4
) ();

    // Byte side
    logic                     Vin;
    logic                     Sin;
    logic [7:0]               Din;

    // Word side
    logic                     Rdy;
    logic [31:0]              Dout;
    logic                     Vout;

    // Status
    logic                     Err;
    logic                     Ovf;
    logic [$clog2(DEPTH):0]   Level;

    modport master (
        output Vin,
        output Sin,
        output Din,
        output Rdy,
        input  Dout,
        input  Vout,
        input  Err,
        input  Ovf,
        input  Level
    );

    modport slave (
        input  Vin,
        input  Sin,
        input  Din,
        input  Rdy,
        output Dout,
        output Vout,
        output Err,
        output Ovf,
        output Level
    );

endinterface

// File: rtl/deserializer.sv
// Deserializer: packs an MSB-first byte stream into 32-bit words framed by a
// start-of-word marker, and buffers completed words in a small FIFO.
// A byte without a start marker while idle, or a start marker mid-word, is a
// framing error. A word completing while the FIFO is full (and not being
// popped on the same edge) is dropped and flagged as an overflow.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module deserializer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    deserializer_if.slave    bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    typedef enum logic {
        StIdle,
        StCollect
    } state_e;

    // Word assembler state
    state_e       state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [31:0]  shift_q, shift_d;

    // Assembler -> FIFO
    logic         push;
    logic [31:0]  push_word;

    // Status pulses
    logic         err_q, err_d;
    logic         ovf_q, ovf_d;

    // FIFO storage and bookkeeping
    logic [31:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic         empty;
    logic         full;
    logic         pop;
    logic         wr_en;

    // Assembler next-state: only qualified bytes advance anything.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        push_word = '0;
        err_d     = 1'b0;

        if (bus.Vin) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.Sin) begin
                        shift_d = {bus.Din, 24'h000000};
                        idx_d   = 2'd1;
                        state_d = StCollect;
                    end else begin
                        // Stray byte with no word open: drop it.
                        err_d = 1'b1;
                    end
                end
                StCollect: begin
                    if (bus.Sin) begin
                        // New word starts before the old one finished:
                        // abandon the partial word and restart.
                        err_d   = 1'b1;
                        shift_d = {bus.Din, 24'h000000};
                        idx_d   = 2'd1;
                    end else begin
                        unique case (idx_q)
                            2'd1: begin
                                shift_d[23:16] = bus.Din;
                                idx_d          = 2'd2;
                            end
                            2'd2: begin
                                shift_d[15:8] = bus.Din;
                                idx_d         = 2'd3;
                            end
                            2'd3: begin
                                push      = 1'b1;
                                push_word = {shift_q[31:8], bus.Din};
                                shift_d   = '0;
                                idx_d     = 2'd0;
                                state_d   = StIdle;
                            end
                            default: begin
                                // idx 0 never occurs while collecting; resync.
                                state_d = StIdle;
                                idx_d   = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    // Assembler and status-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            shift_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO control: a full FIFO still accepts a word if the head leaves on
    // the same edge; the write then lands in the slot being vacated.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FullCnt);
        pop      = !empty && bus.Rdy;
        wr_en    = push && (!full || pop);
        ovf_d    = push && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while empty since Dout is gated.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    // Outputs come straight from registers (no path from the byte inputs).
    assign bus.Dout  = empty ? 32'h0 : mem[rd_ptr_q];
    assign bus.Vout  = !empty;
    assign bus.Level = count_q;
    assign bus.Err   = err_q;
    assign bus.Ovf   = ovf_q;

    // Occupancy can never exceed the FIFO depth.
    a_level_bound : assert property (
        @(posedge clk) disable iff (!rst_n) count_q <= FullCnt
    );

    // A presented word must hold until it is taken.
    a_dout_stable : assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.Vout && !bus.Rdy) |=> $stable(bus.Dout)
    );

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter `DEPTH`, default 4: output FIFO depth in words, a power of 2 and at least 2.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port `Vin`, input, 1 bit: byte-valid qualifier for `Din`/`Sin`.
REQ-005 The block SHALL have port `Sin`, input, 1 bit: start-of-word marker; marks the qualified byte as word byte 0 (MSB).
REQ-006 The block SHALL have port `Din`, input, 8 bits: received byte stream, MSB-first per word.
REQ-007 The block SHALL have port `Rdy`, input, 1 bit: downstream ready.
REQ-008 The block SHALL have port `Dout`, output, 32 bits: FIFO head word.
REQ-009 The block SHALL have port `Vout`, output, 1 bit: FIFO non-empty, i.e. `Dout` is valid.
REQ-010 The block SHALL have port `Err`, output, 1 bit: one-cycle framing-error pulse.
REQ-011 The block SHALL have port `Ovf`, output, 1 bit: one-cycle overflow pulse, signalling a word was dropped.
REQ-012 The block SHALL have port `Level`, output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-013 The assembler SHALL use states IDLE and COLLECT, plus a 2-bit byte index `idx` and a 32-bit shift register.
REQ-014 Bytes SHALL be processed only in cycles with `Vin`=1; with `Vin`=0, state, `idx` and shift register SHALL hold.
REQ-015 On `Vin`&`Sin` in IDLE, the block SHALL load `Din` into bits [31:24], set `idx`=1 and go to COLLECT.
REQ-016 On `Vin`&!`Sin` in IDLE, the block SHALL discard the byte and pulse `Err` for one cycle, staying in IDLE.
REQ-017 On `Vin`&!`Sin` in COLLECT, the block SHALL place `Din` at byte position `idx` (idx 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]) and increment `idx`.
REQ-018 On `Vin`&`Sin` in COLLECT, the block SHALL discard the partial word, pulse `Err`, and restart with `Din` as byte 0 (`idx`=1, stays in COLLECT).
REQ-019 The edge capturing byte 3 SHALL push the complete word into the FIFO and return the assembler to IDLE with `idx`=0.
REQ-020 Latency SHALL be: with the FIFO empty, `Vout`=1 and `Dout`=word in the cycle immediately after the byte-3 edge.
REQ-021 The FIFO SHALL pop on any edge where `Vout`&`Rdy`; `Rdy` with `Vout`=0 SHALL have no effect.
REQ-022 When push and pop occur on the same edge, both SHALL take effect and `Level` SHALL be unchanged, including when the FIFO is full.
REQ-023 When push occurs with FIFO full and no pop, the new word SHALL be dropped, FIFO contents SHALL be unchanged, and `Ovf` SHALL pulse for one cycle.
REQ-024 FIFO pointers SHALL wrap modulo `DEPTH`; `Level` SHALL range 0..DEPTH.
REQ-025 `Dout` SHALL present the head entry when `Vout`=1, SHALL be 0 when empty, and SHALL be stable while `Vout`=1 and `Rdy`=0.
REQ-026 `Err` and `Ovf` SHALL be registered and SHALL deassert the cycle after the pulse unless a new event occurs.
REQ-027 `Err` and `Ovf` SHALL be independent and MAY pulse in the same cycle.
REQ-028 `Vout`, `Level` and `Dout` SHALL be driven from registers only, with no combinational path from `Vin`, `Din` or `Sin`.

Reset
REQ-029 While `rst_n`=0, regardless of `clk`, the block SHALL force state IDLE, `idx`=0, shift register 0, FIFO empty, `Dout`=0, `Vout`=0, `Err`=0, `Ovf`=0, `Level`=0.
REQ-030 Reset asserted mid-word or with the FIFO non-empty SHALL discard all partial and buffered words.
REQ-031 After reset release, the first qualified byte SHALL require `Sin`=1 to start a word.

Verification
REQ-032 Basic word: bytes DE(Sin=1), AD, BE, EF on 4 consecutive cycles with `Rdy`=1 -> `Dout`=32'hDEADBEEF, `Vout`=1 for exactly 1 cycle, starting the cycle after byte EF; `Err`=`Ovf`=0.
REQ-033 Gaps: same 4 bytes with `Vin`=0 for 3 cycles between each byte -> identical `Dout`, `Vout` one cycle after the last byte.
REQ-034 Framing: 11(Sin), 22, then 33(Sin), 44, 55, 66 -> `Err` pulses once at the 33 edge; the only word output is 32'h33445566.
REQ-035 Overflow: `Rdy`=0, 5 complete words with DEPTH=4 -> `Level`=4, `Ovf` pulses once on the 5th word; popping yields words 1-4 in order.
REQ-036 Full with simultaneous pop: FIFO full, `Rdy`=1 on the edge a word completes -> no `Ovf`, `Level` stays 4, new word appears last.
REQ-037 Async reset: assert `rst_n`=0 between clock edges after byte 2 of a word and with `Level`=2 -> outputs go to 0 immediately; after release, a byte without `Sin` -> `Err` pulses.
